// File: rtl/router_port_arbiter_if.sv
// Request/grant bundle between the input address decoders (master) and one
// output-port arbiter (slave).
interface router_port_arbiter_if #(
   parameter int unsigned N = 16
);
   localparam int unsigned IDX_W = 4;

   logic [N-1:0]     req;
   logic [N-1:0]     done;
   logic [N-1:0]     grant;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic [N-1:0]     busy_n;
   logic             timeout;

   modport master (
      output req, done,
      input  grant, grant_valid, grant_idx, busy_n, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_valid, grant_idx, busy_n, timeout
   );
endinterface

// File: rtl/router_port_arbiter.sv
// Round-robin per-output-port arbiter for the 16-port router: grant held until
// done/abort, then a GAP turnaround. Optional hold watchdog under ARB_TIMEOUT_EN.
module router_port_arbiter #(
   parameter int unsigned N        = 16,
   parameter int unsigned MAX_HOLD = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   router_port_arbiter_if.slave arb
);
   localparam int unsigned IDX_W = 4;
   localparam int unsigned SUM_W = IDX_W + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   if (N < 2 || N > 16) begin : g_bad_n
      $error("router_port_arbiter: N must be in 2..16");
   end
   if (MAX_HOLD < 2) begin : g_bad_hold
      $error("router_port_arbiter: MAX_HOLD must be at least 2");
   end

   logic [1:0]       state_q,  state_d;
   logic [IDX_W-1:0] ptr_q,    ptr_d;
   logic [N-1:0]     grant_q,  grant_d;
   logic             gv_q,     gv_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic [N-1:0]     busy_n_q, busy_n_d;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;
`endif

   logic [N-1:0]     req_rot;
   logic             win_found;
   logic [IDX_W-1:0] win_off;
   logic [SUM_W-1:0] win_sum;
   logic [IDX_W-1:0] win_idx;
   logic [N-1:0]     win_onehot;
   logic             owner_release;
   logic             rel_go;
   logic [IDX_W-1:0] ptr_nxt;

   // Rotate requests so bit 0 is the ptr position; lowest set bit wins.
   always_comb begin
      req_rot   = N'({arb.req, arb.req} >> ptr_q);
      win_found = 1'b0;
      win_off   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            win_found = 1'b1;
            win_off   = IDX_W'(k);
         end
      end
      win_sum    = {1'b0, ptr_q} + {1'b0, win_off};
      win_idx    = (win_sum >= SUM_W'(N)) ? IDX_W'(win_sum - SUM_W'(N)) : IDX_W'(win_sum);
      win_onehot = N'(1) << win_idx;
   end

   // grant_q is one-hot in BUSY, so masking picks out the owner's own bits.
   assign owner_release = (|(arb.done & grant_q)) | ~(|(arb.req & grant_q));
   assign ptr_nxt       = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      gv_d     = gv_q;
      idx_d    = idx_q;
      busy_n_d = busy_n_q;
      rel_go   = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d  = S_BUSY;
               grant_d  = win_onehot;
               gv_d     = 1'b1;
               idx_d    = win_idx;
               busy_n_d = win_onehot;
`ifdef ARB_TIMEOUT_EN
               hold_d   = '0;
`endif
            end
         end
         S_BUSY: begin
            rel_go = owner_release;
`ifdef ARB_TIMEOUT_EN
            // Normal release wins over the watchdog on the same cycle.
            if (!owner_release && hold_q == HOLD_W'(MAX_HOLD - 1)) begin
               rel_go    = 1'b1;
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
`endif
            if (rel_go) begin
               state_d  = S_GAP;
               ptr_d    = ptr_nxt;
               grant_d  = '0;
               gv_d     = 1'b0;
               busy_n_d = '1;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d  = S_IDLE;
            grant_d  = '0;
            gv_d     = 1'b0;
            busy_n_d = '1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         gv_q     <= 1'b0;
         idx_q    <= '0;
         busy_n_q <= '1;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         gv_q     <= gv_d;
         idx_q    <= idx_d;
         busy_n_q <= busy_n_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb.timeout = timeout_q;
`else
   assign arb.timeout = 1'b0;
`endif

   assign arb.grant       = grant_q;
   assign arb.grant_valid = gv_q;
   assign arb.grant_idx   = idx_q;
   assign arb.busy_n      = busy_n_q;
endmodule

// File: tb/tb_router_port_arbiter.sv
// Randomized + directed bench for router_port_arbiter against a queue-free
// owner/pointer reference model; follows ARB_TIMEOUT_EN when defined.
module tb_router_port_arbiter;
   localparam int unsigned N        = 16;
   localparam int unsigned MAX_HOLD = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   bit   chk_en  = 1'b0;

   router_port_arbiter_if #(.N(N)) bus ();

   router_port_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .arb     (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: who owns the port, whose turn is next, cool-down edges.
   int m_owner = -1;
   int m_last  = 0;
   int m_ptr   = 0;
   int m_cool  = 0;
   int m_hold  = 0;
   bit m_to    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] exp_grant();
      return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
   endfunction

   function automatic logic [N-1:0] exp_busy_n();
      return (m_owner >= 0) ? (N'(1) << m_owner) : '1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_last = 0; m_ptr = 0; m_cool = 0; m_hold = 0; m_to = 1'b0;
   endtask

   task automatic model_step();
      bit rel;
      bit wd;
      m_to = 1'b0;
      if (m_owner >= 0) begin
         rel = bus.done[m_owner] || !bus.req[m_owner];
         wd  = 1'b0;
`ifdef ARB_TIMEOUT_EN
         wd = (m_hold == int'(MAX_HOLD) - 1);
`endif
         if (rel || wd) begin
            m_to    = !rel;
            m_ptr   = (m_owner + 1) % int'(N);
            m_owner = -1;
            m_cool  = 1;
         end else begin
            m_hold++;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (m_ptr + k) % int'(N);
            if (bus.req[j]) begin
               m_owner = j;
               m_last  = j;
               m_hold  = 0;
               break;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      #1;
   endtask

   task automatic await_grant(output int n);
      n = 0;
      while (!bus.grant_valid && n < 40) begin
         tick();
         n++;
      end
      if (!bus.grant_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL await_grant: no grant within %0d cycles", n);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && chk_en) begin
         check("grant",       32'(bus.grant),       32'(exp_grant()));
         check("busy_n",      32'(bus.busy_n),      32'(exp_busy_n()));
         check("grant_valid", 32'(bus.grant_valid), 32'(m_owner >= 0));
         check("grant_idx",   32'(bus.grant_idx),   32'(m_last));
         check("timeout",     32'(bus.timeout),     32'(m_to));
      end
   end

   initial begin
      int n;
      logic [N-1:0] r;
      bus.req  = '0;
      bus.done = '0;
      #12;
      check("rst_grant",  32'(bus.grant),       32'h0);
      check("rst_busy_n", 32'(bus.busy_n),      32'hFFFF);
      check("rst_gv",     32'(bus.grant_valid), 32'h0);
      check("rst_idx",    32'(bus.grant_idx),   32'h0);
      check("rst_to",     32'(bus.timeout),     32'h0);
      @(posedge clk);
      #4 reset_n = 1'b1;
      chk_en = 1'b1;

      // Wrap-around from ptr=0
      bus.req = 16'h8001;
      await_grant(n);
      check("wrap_first_idx", 32'(bus.grant_idx), 32'd0);
      check("wrap_first_grant", 32'(bus.grant), 32'h0001);
      bus.done = 16'h0001;
      tick();
      bus.done = '0;
      bus.req  = 16'h8000;
      await_grant(n);
      check("wrap_second_grant", 32'(bus.grant), 32'h8000);
      check("wrap_second_idx", 32'(bus.grant_idx), 32'd15);
      bus.done = 16'h8000;
      tick();
      bus.done = '0;

      // Fairness: all requesting, each owner holds 4 cycles
      bus.req = 16'hFFFF;
      for (int k = 0; k <= int'(N); k++) begin
         await_grant(n);
         check("fair_idx", 32'(bus.grant_idx), 32'(k % int'(N)));
         check("fair_gap", 32'(n), 32'd2);
         repeat (3) tick();
         bus.done = N'(1) << (k % int'(N));
         tick();
         bus.done = '0;
      end
      bus.req = '0;

      // Single request, ptr now 1
      bus.req = 16'h0008;
      await_grant(n);
      check("single_grant",  32'(bus.grant),  32'h0008);
      check("single_idx",    32'(bus.grant_idx), 32'd3);
      check("single_busy_n", 32'(bus.busy_n), 32'h0008);
      bus.done = 16'h0008;
      tick();
      bus.done = '0;
      bus.req  = '0;
      check("single_rel_grant",  32'(bus.grant),  32'h0);
      check("single_rel_busy_n", 32'(bus.busy_n), 32'hFFFF);

      // Abort: ptr=4 picks 5 over 2; non-owner done ignored
      bus.req = 16'h0024;
      await_grant(n);
      check("abort_idx", 32'(bus.grant_idx), 32'd5);
      bus.done = 16'h0080;
      tick();
      bus.done = '0;
      check("abort_nonowner_done", 32'(bus.grant), 32'h0020);
      bus.req = '0;
      tick();
      check("abort_grant", 32'(bus.grant), 32'h0);
      bus.req = 16'h0060;
      await_grant(n);
      check("abort_ptr6", 32'(bus.grant_idx), 32'd6);
      bus.done = 16'h0040;
      tick();
      bus.done = '0;
      bus.req  = '0;

      // Watchdog / indefinite hold
      bus.req = 16'h0004;
      await_grant(n);
      check("wd_idx", 32'(bus.grant_idx), 32'd2);
`ifdef ARB_TIMEOUT_EN
      repeat (MAX_HOLD - 1) tick();
      check("wd_held", 32'(bus.grant), 32'h0004);
      tick();
      check("wd_pulse", 32'(bus.timeout), 32'h1);
      check("wd_rel",   32'(bus.grant),   32'h0);
      bus.req = '0;
      tick();
      check("wd_pulse_end", 32'(bus.timeout), 32'h0);
`else
      repeat (120) tick();
      check("hold_grant",   32'(bus.grant),   32'h0004);
      check("hold_timeout", 32'(bus.timeout), 32'h0);
      bus.done = 16'h0004;
      tick();
      bus.done = '0;
      bus.req  = '0;
      check("hold_rel", 32'(bus.grant), 32'h0);
`endif

      // Asynchronous reset mid-packet with owner 9
      tick();
      tick();
      bus.req = 16'h0200;
      await_grant(n);
      check("rstmid_idx", 32'(bus.grant_idx), 32'd9);
      tick();
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      check("rstmid_grant",  32'(bus.grant),       32'h0);
      check("rstmid_busy_n", 32'(bus.busy_n),      32'hFFFF);
      check("rstmid_idx0",   32'(bus.grant_idx),   32'h0);
      check("rstmid_gv",     32'(bus.grant_valid), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #4 reset_n = 1'b1;
      await_grant(n);
      check("rstmid_regrant", 32'(bus.grant_idx), 32'd9);
      bus.done = 16'h0200;
      tick();
      bus.done = '0;
      bus.req  = '0;

      // Randomized traffic: toggling requests, sparse random done pulses
      r = '0;
      repeat (3000) begin
         for (int i = 0; i < int'(N); i++) begin
            if ($urandom_range(7) == 0) r[i] = ~r[i];
         end
         bus.req  = r;
         bus.done = N'($urandom & $urandom & $urandom);
         tick();
      end
      bus.req  = '0;
      bus.done = '0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
